// File: rtl/e_mdu_if.sv
// E-stage multiply/divide interface: operation request from the pipe
// and the HI/LO/busy view returned to the pipe and hazard unit.
interface e_mdu_if;
   logic        start;
   logic [2:0]  mdop;
   logic [31:0] A_E;
   logic [31:0] B_E;
   logic        req;
   logic        busy;
   logic [31:0] HI_E;
   logic [31:0] LO_E;

   modport master (
      output start, mdop, A_E, B_E, req,
      input  busy, HI_E, LO_E
   );

   modport slave (
      input  start, mdop, A_E, B_E, req,
      output busy, HI_E, LO_E
   );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit. Owns HI/LO and models multi-cycle
// latency: the result is computed at acceptance, parked in a temporary
// pair, and committed to HI/LO when the busy counter expires.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | no op in flight; accepts mult/div/mthi/mtlo
// ST_BUSY | mult/div in flight; counter runs down, commit at 1->0
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic     clk,
   input logic     reset,
   e_mdu_if.slave  mdu
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
   localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_tmp_q, hi_tmp_d;
   logic [31:0] lo_tmp_q, lo_tmp_d;
   logic        dz_q, dz_d;

   logic        accept;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        div_signed;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] div_b_safe;
   logic [31:0] quo_u;
   logic [31:0] rem_u;
   logic [31:0] quo_r;
   logic [31:0] rem_r;
   logic        neg_q;
   logic        neg_r;

   assign accept = mdu.start && !mdu.req && (state_q == ST_IDLE);

   // Products: operands widened to 64 bits so the low 64 bits are exact.
   always_comb begin
      prod_s = {{32{mdu.A_E[31]}}, mdu.A_E} * {{32{mdu.B_E[31]}}, mdu.B_E};
      prod_u = {32'd0, mdu.A_E} * {32'd0, mdu.B_E};
   end

   // Division on magnitudes, then sign fix-up. This sidesteps the
   // INT_MIN / -1 overflow case (magnitude 0x80000000 / 1) and a zero
   // divisor is replaced by 1 so the datapath never divides by zero.
   always_comb begin
      div_signed = (mdu.mdop == OP_DIV);
      div_a      = (div_signed && mdu.A_E[31]) ? (32'd0 - mdu.A_E) : mdu.A_E;
      div_b      = (div_signed && mdu.B_E[31]) ? (32'd0 - mdu.B_E) : mdu.B_E;
      div_b_safe = (div_b == 32'd0) ? 32'd1 : div_b;
      quo_u      = div_a / div_b_safe;
      rem_u      = div_a % div_b_safe;
      neg_q      = div_signed && (mdu.A_E[31] ^ mdu.B_E[31]);
      neg_r      = div_signed && mdu.A_E[31];
      quo_r      = neg_q ? (32'd0 - quo_u) : quo_u;
      rem_r      = neg_r ? (32'd0 - rem_u) : rem_u;
   end

   // State, counter and architectural/temporary registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 5'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         hi_tmp_q <= 32'd0;
         lo_tmp_q <= 32'd0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         hi_tmp_q <= hi_tmp_d;
         lo_tmp_q <= lo_tmp_d;
         dz_q     <= dz_d;
      end
   end

   // Next-state: accept in idle, count down and commit in busy.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      hi_tmp_d = hi_tmp_q;
      lo_tmp_d = lo_tmp_q;
      dz_d     = dz_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (mdu.mdop)
                  OP_MULT: begin
                     hi_tmp_d = prod_s[63:32];
                     lo_tmp_d = prod_s[31:0];
                     dz_d     = 1'b0;
                     cnt_d    = MULT_CNT;
                     state_d  = ST_BUSY;
                  end
                  OP_MULTU: begin
                     hi_tmp_d = prod_u[63:32];
                     lo_tmp_d = prod_u[31:0];
                     dz_d     = 1'b0;
                     cnt_d    = MULT_CNT;
                     state_d  = ST_BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     hi_tmp_d = rem_r;
                     lo_tmp_d = quo_r;
                     dz_d     = (mdu.B_E == 32'd0);
                     cnt_d    = DIV_CNT;
                     state_d  = ST_BUSY;
                  end
                  OP_MTHI: hi_d = mdu.A_E;
                  OP_MTLO: lo_d = mdu.A_E;
                  default: ;
               endcase
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d = ST_IDLE;
               // A zero divisor leaves HI/LO untouched.
               if (!dz_q) begin
                  hi_d = hi_tmp_q;
                  lo_d = lo_tmp_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mdu.busy = (state_q == ST_BUSY);
   assign mdu.HI_E = hi_q;
   assign mdu.LO_E = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: hand-computed HI/LO and busy lengths.
module tb_e_mdu;
   localparam logic [2:0] OP_NONE  = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;
   localparam logic [2:0] OP_RSVD  = 3'b111;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_bad;
   int   n;

   e_mdu_if mdu_if ();

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (mdu_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one op for one edge; returns at the negedge after that edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic rq);
      @(negedge clk);
      mdu_if.start = 1'b1;
      mdu_if.mdop  = op;
      mdu_if.A_E   = a;
      mdu_if.B_E   = b;
      mdu_if.req   = rq;
      @(negedge clk);
      mdu_if.start = 1'b0;
      mdu_if.mdop  = OP_NONE;
      mdu_if.req   = 1'b0;
   endtask

   // Count negedges with busy high, bounded.
   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (mdu_if.busy && cnt < 64) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      mdu_if.start = 1'b0;
      mdu_if.mdop  = OP_NONE;
      mdu_if.A_E   = 32'd0;
      mdu_if.B_E   = 32'd0;
      mdu_if.req   = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      chk("rst_busy", {31'd0, mdu_if.busy}, 32'd0);
      chk("rst_hi", mdu_if.HI_E, 32'd0);
      chk("rst_lo", mdu_if.LO_E, 32'd0);

      // Signed multiply: -1 * 2
      issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
      chk("mult_hi_early", mdu_if.HI_E, 32'd0);
      wait_idle(n);
      chk("mult_busy_len", n, 32'd5);
      chk("mult_hi", mdu_if.HI_E, 32'hFFFF_FFFF);
      chk("mult_lo", mdu_if.LO_E, 32'hFFFF_FFFE);

      // Unsigned multiply, same operands
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      wait_idle(n);
      chk("multu_busy_len", n, 32'd5);
      chk("multu_hi", mdu_if.HI_E, 32'h0000_0001);
      chk("multu_lo", mdu_if.LO_E, 32'hFFFF_FFFE);

      // INT_MIN * INT_MIN signed = 2^62
      issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
      wait_idle(n);
      chk("mult_min_hi", mdu_if.HI_E, 32'h4000_0000);
      chk("mult_min_lo", mdu_if.LO_E, 32'h0000_0000);

      // Signed divide -7 / 2
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      wait_idle(n);
      chk("div_busy_len", n, 32'd10);
      chk("div_lo", mdu_if.LO_E, 32'hFFFF_FFFD);
      chk("div_hi", mdu_if.HI_E, 32'hFFFF_FFFF);

      // Signed divide 7 / -2
      issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
      wait_idle(n);
      chk("div_nd_lo", mdu_if.LO_E, 32'hFFFF_FFFD);
      chk("div_nd_hi", mdu_if.HI_E, 32'h0000_0001);

      // Unsigned divide 7 / 2
      issue(OP_DIVU, 32'd7, 32'd2, 1'b0);
      wait_idle(n);
      chk("divu_busy_len", n, 32'd10);
      chk("divu_lo", mdu_if.LO_E, 32'd3);
      chk("divu_hi", mdu_if.HI_E, 32'd1);

      // Overflow case INT_MIN / -1
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_idle(n);
      chk("div_ovf_lo", mdu_if.LO_E, 32'h8000_0000);
      chk("div_ovf_hi", mdu_if.HI_E, 32'h0000_0000);

      // Divide by zero keeps preloaded HI/LO
      issue(OP_MTHI, 32'h11, 32'd0, 1'b0);
      chk("mthi_busy", {31'd0, mdu_if.busy}, 32'd0);
      issue(OP_MTLO, 32'h22, 32'd0, 1'b0);
      chk("mthi_hi", mdu_if.HI_E, 32'h11);
      chk("mtlo_lo", mdu_if.LO_E, 32'h22);
      issue(OP_DIV, 32'd1234, 32'd0, 1'b0);
      wait_idle(n);
      chk("dz_busy_len", n, 32'd10);
      chk("dz_hi", mdu_if.HI_E, 32'h11);
      chk("dz_lo", mdu_if.LO_E, 32'h22);

      // Reserved and none opcodes do nothing
      issue(OP_RSVD, 32'h99, 32'h99, 1'b0);
      chk("rsvd_busy", {31'd0, mdu_if.busy}, 32'd0);
      issue(OP_NONE, 32'h98, 32'h98, 1'b0);
      chk("none_hi", mdu_if.HI_E, 32'h11);
      chk("none_lo", mdu_if.LO_E, 32'h22);

      // Flush blocks mtlo and mult
      issue(OP_MTLO, 32'h55, 32'd0, 1'b1);
      chk("flush_mtlo_lo", mdu_if.LO_E, 32'h22);
      issue(OP_MULT, 32'd3, 32'd4, 1'b1);
      chk("flush_mult_busy", {31'd0, mdu_if.busy}, 32'd0);
      issue(OP_MTHI, 32'h66, 32'd0, 1'b1);
      chk("flush_mthi_hi", mdu_if.HI_E, 32'h11);

      // Flush during busy cycle 3 does not abort an in-flight mult
      issue(OP_MULT, 32'd3, 32'd4, 1'b0);
      @(negedge clk);
      @(negedge clk);
      mdu_if.req = 1'b1;
      @(negedge clk);
      mdu_if.req = 1'b0;
      wait_idle(n);
      chk("flush_inflight_len", n + 3, 32'd5);
      chk("flush_inflight_hi", mdu_if.HI_E, 32'd0);
      chk("flush_inflight_lo", mdu_if.LO_E, 32'd12);

      // Start while busy is ignored: divu 100/7 = 14 r 2
      issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
      @(negedge clk);
      @(negedge clk);
      mdu_if.start = 1'b1;
      mdu_if.mdop  = OP_MTHI;
      mdu_if.A_E   = 32'hAA;
      @(negedge clk);
      mdu_if.start = 1'b0;
      mdu_if.mdop  = OP_NONE;
      chk("sib_hi_mid", mdu_if.HI_E, 32'd0);
      wait_idle(n);
      chk("sib_busy_len", n + 3, 32'd10);
      chk("sib_hi", mdu_if.HI_E, 32'd2);
      chk("sib_lo", mdu_if.LO_E, 32'd14);

      // Reset mid-op clears at once and suppresses late writeback
      issue(OP_MTHI, 32'h33, 32'd0, 1'b0);
      issue(OP_MULT, 32'd5, 32'd6, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rmid_busy", {31'd0, mdu_if.busy}, 32'd0);
      chk("rmid_hi", mdu_if.HI_E, 32'd0);
      chk("rmid_lo", mdu_if.LO_E, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("rmid_late_busy", {31'd0, mdu_if.busy}, 32'd0);
      chk("rmid_late_hi", mdu_if.HI_E, 32'd0);
      chk("rmid_late_lo", mdu_if.LO_E, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
